// File: rtl/vga_timing_gen.sv
// VGA raster timing and RGB565 test-pattern generator on sclk with an internal pixel strobe.
// Counters and every output update together on the pixel-strobe edge and hold in between.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    output logic        pix_en,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        frame_start,
    output logic [15:0] vga_rgb
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int BAR_W   = H_ACT / 8;

    localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_END    = 12'(H_SYNC);
    localparam logic [11:0] VS_END    = 12'(V_SYNC);
    localparam logic [11:0] HA_START  = 12'(H_SYNC + H_BP);
    localparam logic [11:0] HA_END    = 12'(H_SYNC + H_BP + H_ACT);
    localparam logic [11:0] VA_START  = 12'(V_SYNC + V_BP);
    localparam logic [11:0] VA_END    = 12'(V_SYNC + V_BP + V_ACT);
    localparam logic [11:0] X_LAST    = 12'(H_ACT - 1);
    localparam logic [11:0] Y_LAST    = 12'(V_ACT - 1);

    logic [3:0]  div_cnt;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [1:0]  mode_q;
    logic [15:0] solid_q;

    logic        tick;
    logic [11:0] h_nxt;
    logic [11:0] v_nxt;
    logic        frame_nxt;
    logic        de_nxt;
    logic [11:0] x_nxt;
    logic [11:0] y_nxt;
    logic [1:0]  mode_nxt;
    logic [15:0] solid_nxt;
    logic [2:0]  bar;
    logic [15:0] bar_rgb;
    logic        grid_on;
    logic [15:0] rgb_nxt;

    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        h_nxt = (h_cnt == H_LAST) ? 12'd0 : h_cnt + 12'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            v_nxt = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end
        frame_nxt = (h_nxt == 12'd0) && (v_nxt == 12'd0);
        de_nxt    = (h_nxt >= HA_START) && (h_nxt < HA_END) &&
                    (v_nxt >= VA_START) && (v_nxt < VA_END);
        x_nxt     = de_nxt ? h_nxt - HA_START : 12'd0;
        y_nxt     = de_nxt ? v_nxt - VA_START : 12'd0;
        // a new frame's pattern selection applies from its very first pixel
        mode_nxt  = frame_nxt ? mode : mode_q;
        solid_nxt = frame_nxt ? solid_rgb : solid_q;
    end

    // bar index by compare chain against constant bar boundaries
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_nxt >= 12'(k * BAR_W)) bar = 3'(k);
        end
        case (bar)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    end

    always_comb begin
        grid_on = (x_nxt[4:0] == 5'd0) || (y_nxt[4:0] == 5'd0) ||
                  (x_nxt == X_LAST) || (y_nxt == Y_LAST);
        rgb_nxt = 16'h0000;
        if (de_nxt) begin
            case (mode_nxt)
                2'd0:    rgb_nxt = solid_nxt;
                2'd1:    rgb_nxt = bar_rgb;
                2'd2:    rgb_nxt = grid_on ? 16'hFFFF : 16'h0000;
                default: rgb_nxt = {x_nxt[8:4], y_nxt[8:3], 5'b0};
            endcase
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            div_cnt     <= 4'd0;
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            mode_q      <= 2'd0;
            solid_q     <= 16'h0000;
            pix_en      <= 1'b0;
            vga_hsync   <= ~SYNC_POL;
            vga_vsync   <= ~SYNC_POL;
            vga_de      <= 1'b0;
            pix_x       <= 12'd0;
            pix_y       <= 12'd0;
            frame_start <= 1'b0;
            vga_rgb     <= 16'h0000;
        end else begin
            div_cnt     <= tick ? 4'd0 : div_cnt + 4'd1;
            pix_en      <= tick;
            frame_start <= tick && frame_nxt;
            if (tick) begin
                h_cnt     <= h_nxt;
                v_cnt     <= v_nxt;
                mode_q    <= mode_nxt;
                solid_q   <= solid_nxt;
                vga_hsync <= (h_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
                vga_vsync <= (v_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
                vga_de    <= de_nxt;
                pix_x     <= x_nxt;
                pix_y     <= y_nxt;
                vga_rgb   <= rgb_nxt;
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing and test-pattern generator: next generation of the fixed 640x480 VGA driver fed by a divide-by-2 toggle clock.
- Runs on the system clock with an internal pixel clock-enable (no derived clock).
- Produces hsync/vsync/data-enable, active-area pixel coordinates, a frame-start strobe and an RGB565 test pattern selectable per frame.
- Sits between the system clock/reset and the VGA pins in the top level.

Parameters:
- CLK_DIV, 2, sclk cycles per pixel (1..16; 1 = pix_en always high)
- H_SYNC, 96, hsync width in pixels
- H_BP, 48, horizontal back porch in pixels
- H_ACT, 640, active pixels per line (multiple of 8, <=2048)
- H_FP, 16, horizontal front porch in pixels
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- V_ACT, 480, active lines (<=2048)
- V_FP, 10, vertical front porch in lines
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- sclk, in, 1, system clock
- s_rst_n, in, 1, asynchronous active-low reset
- mode, in, 2, pattern select: 0 solid, 1 colour bars, 2 grid, 3 gradient
- solid_rgb, in, 16, RGB565 colour for mode 0
- pix_en, out, 1, one-sclk pixel strobe
- vga_hsync, out, 1, horizontal sync
- vga_vsync, out, 1, vertical sync
- vga_de, out, 1, active-video enable
- pix_x, out, 12, active-area column, 0 outside active
- pix_y, out, 12, active-area row, 0 outside active
- frame_start, out, 1, one-sclk pulse at the first pixel of each frame
- vga_rgb, out, 16, RGB565 pixel data

Behaviour:
- Clock and reset: one clock (sclk); reset is asynchronous, active-low (s_rst_n).
- Reset values:
  - div_cnt=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, mode_q=0
  - pix_en=0, vga_de=0, pix_x=0, pix_y=0, frame_start=0, vga_rgb=0
  - hsync/vsync at inactive level (~SYNC_POL)
  - Reset assertion mid-frame returns to these values immediately.
- Totals: H_TOTAL=H_SYNC+H_BP+H_ACT+H_FP; V_TOTAL likewise.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en is registered high for exactly one sclk when div_cnt wraps, giving one pulse every CLK_DIV cycles. The first pix_en occurs CLK_DIV cycles after reset release.
- Counters advance only on cycles with pix_en high:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt wraps and itself wraps V_TOTAL-1 -> 0.
  - The first pix_en after reset therefore lands on (0,0).
- Outputs are registered and valid on the same edge the counters take their new value; zero latency relative to (h_cnt, v_cnt). Outputs are held between pix_en strobes.
- Region decode:
  - hsync active while h_cnt < H_SYNC.
  - vsync active while v_cnt < V_SYNC.
  - de = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) AND v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT).
- Coordinates: pix_x = h_cnt-(H_SYNC+H_BP) and pix_y = v_cnt-(V_SYNC+V_BP) when de=1; both 0 otherwise.
- frame_start: high for the single sclk in which the counters become (0,0).
- mode/solid_rgb sampling: captured into mode_q/solid_q only at that same edge. Changes mid-frame take effect at the next frame; no tearing.
- Patterns (vga_rgb=0 whenever de=0):
  - mode 0: solid_q.
  - mode 1: 8 equal bars, bar = pix_x/(H_ACT/8). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mode 2: FFFF when pix_x[4:0]==0 or pix_y[4:0]==0, or pix_x==H_ACT-1, or pix_y==V_ACT-1; else 0000.
  - mode 3: {pix_x[8:4], pix_y[8:3], 5'b0}.
- Arithmetic: all counters 12-bit unsigned; bar index computed with a compare chain or divider constant, no runtime divider.

Test Plan:
1. Defaults; hold reset 5 cycles, release.
   - During reset: hsync=vsync=1, de=0, rgb=0.
   - First pix_en at cycle 2, with frame_start coincident.
2. Defaults, free-run 2 frames.
   - hsync low for 192 sclk per line; line period 1600 sclk.
   - vsync low for 3200 sclk; frame period 840000 sclk.
   - de high 1280 sclk per active line, 480 lines.
   - frame_start exactly once per frame.
3. mode=1.
   - pix_x=0 -> FFFF; pix_x=80 -> FFE0; pix_x=639 -> 0000.
   - pix_y at first active line = 0, last = 479.
4. mode=0 with solid_rgb=1234; switch to mode=2 at line 100.
   - Rest of frame stays 1234.
   - Next frame: pix (0,5)=FFFF, pix (3,5)=0000.
5. CLK_DIV=1, SYNC_POL=1, H 2/2/8/2, V 1/1/4/1.
   - pix_en constant 1; hsync high 2 of 14 cycles.
   - Frame = 98 cycles.
   - mode 1 yields one colour per pixel across the 8 pixels.
6. Assert s_rst_n mid active line; release.
   - Outputs return to reset values asynchronously.
   - Restart at (0,0) with frame_start and mode re-sampled.
